phase_check_scheduler: RTL and testbench

PHASE_CHECK_SCHEDULER -- requirements
Module: phase_check_scheduler

---
 rtl/phase_check_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_phase_check_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_check_scheduler.sv
// phase_check_scheduler
// Sequences one shared phase_shift_check instance across the PLL outputs:
// for each channel it waits for PLL lock, holds the checker in reset for
// SETTLE cycles, then measures for WINDOW cycles, recording sticky failures.
// A loss of lock during settle/measure discards the channel's partial
// result and retries the same channel.
//
// Optional feature: define PHASE_CHECK_TIMEOUT_EN to bound WAIT_LOCK to
// LOCK_TIMEOUT cycles; an expired channel is flagged in timeout and result.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   LOCKED     in   PLL lock indication
//   start      in   single-cycle sweep request (honoured in IDLE/DONE only)
//   check_fail in   fail flag from the shared checker
//   chk_rst    out  checker reset (low only while measuring)
//   chk_sel    out  channel index steering the checker input mux
//   busy       out  sweep in progress
//   done       out  sweep complete, results valid
//   result     out  per-channel fail bits
//   any_fail   out  OR of result
//   timeout    out  per-channel lock-timeout bits
module phase_check_scheduler #(
  parameter int unsigned CHANNELS     = 6,
  parameter int unsigned SETTLE       = 4,
  parameter int unsigned WINDOW       = 1000,
  parameter int unsigned LOCK_TIMEOUT = 10000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                LOCKED,
  input  logic                start,
  input  logic                check_fail,
  output logic                chk_rst,
  output logic [2:0]          chk_sel,
  output logic                busy,
  output logic                done,
  output logic [CHANNELS-1:0] result,
  output logic                any_fail,
  output logic [CHANNELS-1:0] timeout
);

  localparam int unsigned MAX_SW  = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int unsigned MAX_ALL = (MAX_SW > LOCK_TIMEOUT) ? MAX_SW : LOCK_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(MAX_ALL + 1);

  // Counter load values: the counter runs down to zero, so N cycles load N-1.
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] WINDOW_LD = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] LOCK_LD   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [2:0]       LAST_SEL  = 3'(CHANNELS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_RESET_CHK = 3'd2,
    S_MEASURE   = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [2:0]          r_sel;
  logic [2:0]          w_sel_nxt;
  logic [CHANNELS-1:0] r_result;
  logic [CHANNELS-1:0] w_result_nxt;
  logic                r_pfail;
  logic                w_pfail_nxt;
  logic [CHANNELS-1:0] w_sel_mask;
  logic                w_last;
`ifdef PHASE_CHECK_TIMEOUT_EN
  logic [CHANNELS-1:0] r_timeout;
  logic [CHANNELS-1:0] w_timeout_nxt;
`endif

  assign w_sel_mask = CHANNELS'(1) << r_sel;
  assign w_last     = (r_sel == LAST_SEL);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers (counter, channel index, results)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_sel    <= '0;
      r_result <= '0;
      r_pfail  <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_sel    <= w_sel_nxt;
      r_result <= w_result_nxt;
      r_pfail  <= w_pfail_nxt;
    end
  end

`ifdef PHASE_CHECK_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout <= '0;
    end else begin
      r_timeout <= w_timeout_nxt;
    end
  end
`endif

  // Next-state and datapath update; the counter is reloaded on every state entry
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_sel_nxt    = r_sel;
    w_result_nxt = r_result;
    w_pfail_nxt  = r_pfail;
`ifdef PHASE_CHECK_TIMEOUT_EN
    w_timeout_nxt = r_timeout;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt  = S_WAIT_LOCK;
          w_cnt_nxt    = LOCK_LD;
          w_sel_nxt    = '0;
          w_result_nxt = '0;
          w_pfail_nxt  = 1'b0;
`ifdef PHASE_CHECK_TIMEOUT_EN
          w_timeout_nxt = '0;
`endif
        end
      end
      S_WAIT_LOCK: begin
        if (LOCKED) begin
          w_state_nxt = S_RESET_CHK;
          w_cnt_nxt   = SETTLE_LD;
          w_pfail_nxt = 1'b0;
`ifdef PHASE_CHECK_TIMEOUT_EN
        end else if (r_cnt == '0) begin
          // Lock never arrived: flag the channel and move on
          w_timeout_nxt = r_timeout | w_sel_mask;
          w_result_nxt  = r_result | w_sel_mask;
          if (w_last) begin
            w_state_nxt = S_DONE;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_WAIT_LOCK;
            w_cnt_nxt   = LOCK_LD;
            w_sel_nxt   = 3'(r_sel + 3'd1);
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
`endif
        end
      end
      S_RESET_CHK: begin
        if (!LOCKED) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = LOCK_LD;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_MEASURE;
          w_cnt_nxt   = WINDOW_LD;
          w_pfail_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_MEASURE: begin
        if (!LOCKED) begin
          // Lock lost: drop the partial fail and retry this channel
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = LOCK_LD;
          w_pfail_nxt = 1'b0;
        end else if (r_cnt == '0) begin
          // Last window cycle: commit including this cycle's check_fail
          if (r_pfail || check_fail) begin
            w_result_nxt = r_result | w_sel_mask;
          end
          w_pfail_nxt = 1'b0;
          if (w_last) begin
            w_state_nxt = S_DONE;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_WAIT_LOCK;
            w_cnt_nxt   = LOCK_LD;
            w_sel_nxt   = 3'(r_sel + 3'd1);
          end
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
          w_pfail_nxt = r_pfail | check_fail;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Moore output decode from the state register
  always_comb begin
    busy    = 1'b1;
    done    = 1'b0;
    chk_rst = 1'b1;
    case (r_state)
      S_IDLE:    busy = 1'b0;
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      S_MEASURE: chk_rst = 1'b0;
      default:   ;
    endcase
  end

  assign chk_sel  = r_sel;
  assign result   = r_result;
  assign any_fail = |r_result;
`ifdef PHASE_CHECK_TIMEOUT_EN
  assign timeout  = r_timeout;
`else
  assign timeout  = '0;
`endif

endmodule

// File: tb/tb_phase_check_scheduler.sv
// Testbench for phase_check_scheduler: directed scenarios plus randomized
// back-to-back sweeps against a cycle-position model of the sweep schedule.
module tb_phase_check_scheduler;

  localparam int CH       = 6;
  localparam int ST       = 4;
  localparam int WN       = 1000;
  localparam int LT       = 100;
  localparam int CHAN_LEN = 1 + ST + WN;        // cycles per channel with lock steady
  localparam int SWEEP    = 1 + CH * CHAN_LEN;  // start-to-done latency

  logic          clk = 1'b0;
  logic          rst;
  logic          LOCKED;
  logic          start;
  logic          check_fail;
  logic          chk_rst;
  logic [2:0]    chk_sel;
  logic          busy;
  logic          done;
  logic [CH-1:0] result;
  logic          any_fail;
  logic [CH-1:0] timeout;

  int n_cmp = 0;
  int n_err = 0;

  phase_check_scheduler #(
    .CHANNELS    (CH),
    .SETTLE      (ST),
    .WINDOW      (WN),
    .LOCK_TIMEOUT(LT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .LOCKED    (LOCKED),
    .start     (start),
    .check_fail(check_fail),
    .chk_rst   (chk_rst),
    .chk_sel   (chk_sel),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .any_fail  (any_fail),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Cycle n is the cycle after the n-th edge counted from the start-sampling edge.
  // With lock steady, each channel spends 1 cycle waiting, ST settling, WN measuring.
  function automatic bit in_measure(input int n);
    if (n < 1 || n > CH * CHAN_LEN) return 1'b0;
    return ((n - 1) % CHAN_LEN) >= (1 + ST);
  endfunction

  function automatic int chan_of(input int n);
    return (n - 1) / CHAN_LEN;
  endfunction

  // Runs one sweep with LOCKED high, pulsing check_fail in cycles fa/fb and
  // start in cycle st (0 = none); returns done cycle (-1 if never) and the
  // result the schedule predicts.
  task automatic run_sweep(input int fa, input int fb, input int st,
                           output int done_cyc, output logic [CH-1:0] exp_res);
    exp_res = '0;
    if (in_measure(fa)) exp_res[chan_of(fa)] = 1'b1;
    if (in_measure(fb)) exp_res[chan_of(fb)] = 1'b1;
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= SWEEP + 50; n++) begin
      @(posedge clk);
      #1;
      start = (n == st);
      if (done === 1'b1) begin
        done_cyc = n;
        break;
      end
      check_fail = (n == fa) || (n == fb);
    end
    start      = 1'b0;
    check_fail = 1'b0;
  endtask

  task automatic test_reset();
    logic [18:0] snap;
    rst = 1'b1; LOCKED = 1'b1; start = 1'b0; check_fail = 1'b0;
    repeat (3) @(negedge clk);
    snap = {chk_rst, chk_sel, busy, done, result, any_fail, timeout};
    n_cmp++;
    if (snap !== {1'b1, 3'd0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0}) begin
      n_err++;
      $display("FAIL reset_values: got %b expected %b", snap, {1'b1, 3'd0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL idle_hold: busy=%b done=%b expected 0/0", busy, done);
    end
  endtask

  task automatic test_nominal();
    int d; logic [CH-1:0] e;
    run_sweep(0, 0, 0, d, e);
    n_cmp++;
    if (d !== SWEEP) begin n_err++; $display("FAIL nominal_latency: got %0d expected %0d", d, SWEEP); end
    n_cmp++;
    if (result !== 6'b000000 || any_fail !== 1'b0) begin
      n_err++; $display("FAIL nominal_result: got %b/%b expected 000000/0", result, any_fail);
    end
    n_cmp++;
    if (timeout !== '0 || chk_sel !== 3'(CH - 1) || busy !== 1'b0) begin
      n_err++; $display("FAIL nominal_done_state: timeout=%b sel=%0d busy=%b", timeout, chk_sel, busy);
    end
  endtask

  // Fail mid-window of channel 3, plus a start pulse while busy that must be ignored
  task automatic test_single_fail();
    int d; logic [CH-1:0] e;
    run_sweep(3 * CHAN_LEN + 1 + 1 + ST + 500, 0, 4500, d, e);
    n_cmp++;
    if (d !== SWEEP) begin n_err++; $display("FAIL single_latency: got %0d expected %0d", d, SWEEP); end
    n_cmp++;
    if (result !== e || e !== 6'b001000 || any_fail !== 1'b1) begin
      n_err++; $display("FAIL single_result: got %b/%b expected %b/1", result, any_fail, e);
    end
  endtask

  // Fail only during the settle of channel 2 must not count
  task automatic test_reset_chk_fail();
    int d; logic [CH-1:0] e;
    run_sweep(2 * CHAN_LEN + 2, 2 * CHAN_LEN + 1 + ST, 0, d, e);
    n_cmp++;
    if (d !== SWEEP || result !== e || any_fail !== 1'b0) begin
      n_err++; $display("FAIL settle_fail: done=%0d result=%b any=%b expected %0d/%b/0", d, result, any_fail, SWEEP, e);
    end
  endtask

  // Fails on the first window cycle of channel 0 and the last of channel 5; DONE holds
  task automatic test_boundary();
    int d; logic [CH-1:0] e;
    run_sweep(2 + ST, CH * CHAN_LEN, 0, d, e);
    n_cmp++;
    if (d !== SWEEP || result !== e || e !== 6'b100001) begin
      n_err++; $display("FAIL boundary_result: done=%0d result=%b expected %0d/%b", d, result, SWEEP, e);
    end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b1 || result !== e || chk_sel !== 3'(CH - 1)) begin
      n_err++; $display("FAIL done_hold: done=%b result=%b sel=%0d expected 1/%b/%0d", done, result, chk_sel, e, CH - 1);
    end
  endtask

  // Lock lost 10 cycles into channel 1's window with check_fail high, back 50 cycles later
  task automatic test_abort();
    int n0, mstart, drop, exp_done, d;
    n0       = CHAN_LEN + 1;
    mstart   = n0 + 1 + ST;
    drop     = mstart + 10;
    exp_done = SWEEP + (drop - n0) + 50;
    d        = -1;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= exp_done + 50; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done === 1'b1) begin d = n; break; end
      if (n == drop + 5) begin
        n_cmp++;
        if (chk_sel !== 3'd1 || chk_rst !== 1'b1 || busy !== 1'b1) begin
          n_err++; $display("FAIL abort_retry_state: sel=%0d chk_rst=%b busy=%b expected 1/1/1", chk_sel, chk_rst, busy);
        end
      end
      LOCKED     = !(n >= drop && n < drop + 50);
      check_fail = (n >= mstart && n < drop + 50);
    end
    LOCKED = 1'b1; check_fail = 1'b0;
    n_cmp++;
    if (d !== exp_done) begin n_err++; $display("FAIL abort_latency: got %0d expected %0d", d, exp_done); end
    n_cmp++;
    if (result !== 6'b000000) begin n_err++; $display("FAIL abort_result: got %b expected 000000", result); end
  endtask

  // Asynchronous reset in the middle of channel 4's window
  task automatic test_reset_mid();
    int nr;
    logic [18:0] snap;
    nr = 4 * CHAN_LEN + 1 + 1 + ST + 100;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= nr; n++) begin
      @(posedge clk);
      #1;
      start      = 1'b0;
      check_fail = (n == 500);
    end
    check_fail = 1'b0;
    n_cmp++;
    if (result !== 6'b000001 || chk_sel !== 3'd4 || chk_rst !== 1'b0) begin
      n_err++; $display("FAIL pre_reset_state: result=%b sel=%0d chk_rst=%b expected 000001/4/0", result, chk_sel, chk_rst);
    end
    #2 rst = 1'b1;
    #1;
    snap = {chk_rst, chk_sel, busy, done, result, any_fail, timeout};
    n_cmp++;
    if (snap !== {1'b1, 3'd0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0}) begin
      n_err++; $display("FAIL async_reset: got %b expected %b", snap, {1'b1, 3'd0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0});
    end
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || chk_sel !== 3'd0 || result !== '0) begin
      n_err++; $display("FAIL start_after_reset: busy=%b sel=%0d result=%b expected 1/0/0", busy, chk_sel, result);
    end
    #2 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  // No lock at all: either every channel times out, or the sweep waits forever
  task automatic test_lock_wait();
    int d;
    LOCKED = 1'b0;
    d      = -1;
    @(negedge clk);
    start = 1'b1;
`ifdef PHASE_CHECK_TIMEOUT_EN
    for (int n = 1; n <= 1 + CH * LT + 50; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) begin d = n; break; end
    end
    n_cmp++;
    if (d !== 1 + CH * LT || timeout !== 6'b111111 || result !== 6'b111111 || any_fail !== 1'b1) begin
      n_err++; $display("FAIL lock_timeout: done=%0d timeout=%b result=%b expected %0d/111111/111111", d, timeout, result, 1 + CH * LT);
    end
`else
    for (int n = 1; n <= 3 * LT; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) d = n;
    end
    n_cmp++;
    if (d !== -1 || busy !== 1'b1 || timeout !== '0 || chk_sel !== 3'd0 || chk_rst !== 1'b1) begin
      n_err++; $display("FAIL lock_wait: done_at=%0d busy=%b timeout=%b sel=%0d chk_rst=%b expected -1/1/0/0/1", d, busy, timeout, chk_sel, chk_rst);
    end
`endif
    LOCKED = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Back-to-back randomized sweeps restarted straight from DONE
  task automatic test_back_to_back();
    for (int s = 0; s < 3; s++) begin
      int rate, d;
      logic [CH-1:0] e;
      logic [2:0] es;
      logic cf, er;
      rate = int'($urandom_range(300, 4000));
      e    = '0;
      d    = -1;
      @(negedge clk);
      start = 1'b1;
      for (int n = 1; n <= SWEEP + 50; n++) begin
        @(posedge clk); #1;
        start = 1'b0;
        if (done === 1'b1) begin d = n; break; end
        if (n % 97 == 0) begin
          es = 3'(chan_of(n));
          er = !in_measure(n);
          n_cmp++;
          if ({busy, chk_rst, chk_sel} !== {1'b1, er, es}) begin
            n_err++; $display("FAIL sched_c%0d: busy/chk_rst/sel=%b expected %b", n, {busy, chk_rst, chk_sel}, {1'b1, er, es});
          end
        end
        cf = ($urandom_range(0, rate) == 0);
        check_fail = cf;
        if (cf && in_measure(n)) e[chan_of(n)] = 1'b1;
      end
      check_fail = 1'b0;
      n_cmp++;
      if (d !== SWEEP) begin n_err++; $display("FAIL rand%0d_latency: got %0d expected %0d", s, d, SWEEP); end
      n_cmp++;
      if (result !== e || any_fail !== (|e) || timeout !== '0) begin
        n_err++; $display("FAIL rand%0d_result: got %b/%b/%b expected %b/%b/0", s, result, any_fail, timeout, e, |e);
      end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (result !== e || done !== 1'b1) begin
        n_err++; $display("FAIL rand%0d_hold: result=%b done=%b expected %b/1", s, result, done, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_single_fail();
    test_reset_chk_fail();
    test_boundary();
    test_abort();
    test_reset_mid();
    test_lock_wait();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
